vga_rect_fill: RTL

Sequencer that drives the 160x120 `vga_adapter` pixel-write port. It fills an axis-aligned rectangle, or the whole screen, one pixel per clock. It sits between user logic (switch/key decode or a game FSM) and the adapter's `x`, `y`, `colour` and `plot` inputs. Rectangles are clipped to the screen, so callers never generate out-of-range writes.

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_rect_fill_if.sv | 29 ++
 rtl/vga_raster_counter.sv | 55 +++++
 rtl/vga_rect_fill.sv | 134 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, state type and clipping helpers for the 160x120 pixel-write path.
package vga_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    // Screen limits are one bit wider than the coordinates so 160/120 compare without wrap.
    localparam logic [X_W:0] SCREEN_W = 9'd160;
    localparam logic [Y_W:0] SCREEN_H = 8'd120;

    localparam logic [X_W-1:0] FULL_W = 8'd160;
    localparam logic [Y_W-1:0] FULL_H = 7'd120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } fill_state_t;

    function automatic logic [X_W:0] clip_w(input logic [X_W-1:0] org, input logic [X_W-1:0] len);
        logic [X_W:0] room;
        room = SCREEN_W - {1'b0, org};
        if ({1'b0, org} >= SCREEN_W) begin
            clip_w = {(X_W+1){1'b0}};
        end else if ({1'b0, len} < room) begin
            clip_w = {1'b0, len};
        end else begin
            clip_w = room;
        end
    endfunction

    function automatic logic [Y_W:0] clip_h(input logic [Y_W-1:0] org, input logic [Y_W-1:0] len);
        logic [Y_W:0] room;
        room = SCREEN_H - {1'b0, org};
        if ({1'b0, org} >= SCREEN_H) begin
            clip_h = {(Y_W+1){1'b0}};
        end else if ({1'b0, len} < room) begin
            clip_h = {1'b0, len};
        end else begin
            clip_h = room;
        end
    endfunction

endpackage

// File: rtl/vga_rect_fill_if.sv
// Request and pixel-write signals between user logic (master) and the fill sequencer (slave).
interface vga_rect_fill_if;
    import vga_pkg::*;

    logic                start;
    logic                clear;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      width;
    logic [Y_W-1:0]      height;
    logic [COLOUR_W-1:0] colour_in;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output start, clear, x0, y0, width, height, colour_in,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, clear, x0, y0, width, height, colour_in,
        output x, y, colour, plot, busy, done
    );

endinterface

// File: rtl/vga_raster_counter.sv
// Loadable 2-D raster counter: x runs origin..end, then wraps to origin while y steps.
module vga_raster_counter
    import vga_pkg::*;
(
    input  logic           clock,
    input  logic           resetn,
    input  logic           load,
    input  logic           en,
    input  logic [X_W-1:0] org_x,
    input  logic [Y_W-1:0] org_y,
    input  logic [X_W-1:0] ext_w,
    input  logic [Y_W-1:0] ext_h,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    localparam logic [X_W-1:0] X_ONE = {{(X_W-1){1'b0}}, 1'b1};
    localparam logic [Y_W-1:0] Y_ONE = {{(Y_W-1){1'b0}}, 1'b1};

    logic [X_W-1:0] x_r;
    logic [Y_W-1:0] y_r;
    logic [X_W-1:0] ox_r;
    logic [X_W-1:0] xe_r;
    logic [Y_W-1:0] ye_r;

    // Position and end-coordinate registers; extents arrive pre-clipped so the ends stay on screen.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_r  <= {X_W{1'b0}};
            y_r  <= {Y_W{1'b0}};
            ox_r <= {X_W{1'b0}};
            xe_r <= {X_W{1'b0}};
            ye_r <= {Y_W{1'b0}};
        end else if (load) begin
            x_r  <= org_x;
            y_r  <= org_y;
            ox_r <= org_x;
            xe_r <= org_x + ext_w - X_ONE;
            ye_r <= org_y + ext_h - Y_ONE;
        end else if (en) begin
            if (x_r == xe_r) begin
                x_r <= ox_r;
                y_r <= y_r + Y_ONE;
            end else begin
                x_r <= x_r + X_ONE;
            end
        end
    end

    assign x    = x_r;
    assign y    = y_r;
    assign last = (x_r == xe_r) && (y_r == ye_r);

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle / full-screen fill sequencer for the 160x120 adapter write port, one pixel per clock.
module vga_rect_fill
    import vga_pkg::*;
(
    input  logic           clock,
    input  logic           resetn,
    vga_rect_fill_if.slave bus
);

    fill_state_t         state_r;
    logic [X_W-1:0]      x0_r;
    logic [Y_W-1:0]      y0_r;
    logic [X_W-1:0]      w_r;
    logic [Y_W-1:0]      h_r;
    logic [COLOUR_W-1:0] colour_r;
    logic [COLOUR_W-1:0] colour_out_r;
    logic                plot_r;
    logic                busy_r;
    logic                done_r;

    logic [X_W:0]        w_eff_s;
    logic [Y_W:0]        h_eff_s;
    logic                empty_s;
    logic                load_s;
    logic                step_s;
    logic                last_s;
    logic [X_W-1:0]      cnt_x_s;
    logic [Y_W-1:0]      cnt_y_s;

    // Clipped extent of the latched request; a zero extent on either axis means nothing to draw.
    always_comb begin
        w_eff_s = clip_w(x0_r, w_r);
        h_eff_s = clip_h(y0_r, h_r);
        empty_s = (w_eff_s == {(X_W+1){1'b0}}) || (h_eff_s == {(Y_W+1){1'b0}});
    end

    assign load_s = (state_r == LOAD) && !empty_s;
    assign step_s = (state_r == DRAW) && !last_s;

    vga_raster_counter u_raster (
        .clock  (clock),
        .resetn (resetn),
        .load   (load_s),
        .en     (step_s),
        .org_x  (x0_r),
        .org_y  (y0_r),
        .ext_w  (w_eff_s[X_W-1:0]),
        .ext_h  (h_eff_s[Y_W-1:0]),
        .x      (cnt_x_s),
        .y      (cnt_y_s),
        .last   (last_s)
    );

    // Control FSM with registered plot/busy/done; plot rises with the counter load so pixel and strobe align.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= IDLE;
            x0_r         <= {X_W{1'b0}};
            y0_r         <= {Y_W{1'b0}};
            w_r          <= {X_W{1'b0}};
            h_r          <= {Y_W{1'b0}};
            colour_r     <= {COLOUR_W{1'b0}};
            colour_out_r <= {COLOUR_W{1'b0}};
            plot_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    plot_r <= 1'b0;
                    done_r <= 1'b0;
                    if (bus.clear) begin
                        x0_r     <= {X_W{1'b0}};
                        y0_r     <= {Y_W{1'b0}};
                        w_r      <= FULL_W;
                        h_r      <= FULL_H;
                        colour_r <= bus.colour_in;
                        busy_r   <= 1'b1;
                        state_r  <= LOAD;
                    end else if (bus.start) begin
                        x0_r     <= bus.x0;
                        y0_r     <= bus.y0;
                        w_r      <= bus.width;
                        h_r      <= bus.height;
                        colour_r <= bus.colour_in;
                        busy_r   <= 1'b1;
                        state_r  <= LOAD;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                LOAD: begin
                    if (empty_s) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        plot_r       <= 1'b1;
                        colour_out_r <= colour_r;
                        state_r      <= DRAW;
                    end
                end
                DRAW: begin
                    if (last_s) begin
                        plot_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= DRAW;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    plot_r  <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.x      = cnt_x_s;
    assign bus.y      = cnt_y_s;
    assign bus.colour = colour_out_r;
    assign bus.plot   = plot_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;

endmodule
